// File: rtl/key_step_debouncer.sv
// Conditions a bouncy active-low push-button and a serial-input switch into a
// one-cycle step pulse with the sampled input bit, a debounced level and a step count.
module key_step_debouncer #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 19,
  parameter int COUNT_W         = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               key_n,
  input  logic               sw_in,
  output logic               step,
  output logic               w_out,
  output logic               pressed,
  output logic [COUNT_W-1:0] step_count
);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               key_meta_q, key_s_q;
  logic               sw_meta_q, sw_s_q;
  logic               step_q, step_d;
  logic               w_q, w_d;
  logic               pressed_q, pressed_d;
  logic [COUNT_W-1:0] count_q, count_d;

  // Synchronizers reset to the released / zero levels so a held key after reset still needs a full interval.
  always_ff @(posedge clock) begin
    if (!reset) begin
      key_meta_q <= 1'b1;
      key_s_q    <= 1'b1;
      sw_meta_q  <= 1'b0;
      sw_s_q     <= 1'b0;
    end else begin
      key_meta_q <= key_n;
      key_s_q    <= key_meta_q;
      sw_meta_q  <= sw_in;
      sw_s_q     <= sw_meta_q;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      step_q    <= 1'b0;
      w_q       <= 1'b0;
      pressed_q <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      step_q    <= step_d;
      w_q       <= w_d;
      pressed_q <= pressed_d;
      count_q   <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    step_d  = 1'b0;
    w_d     = w_q;
    count_d = count_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!key_s_q) state_d = PRESS_WAIT;
      end
      PRESS_WAIT: begin
        if (key_s_q) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d = HELD;
          cnt_d   = '0;
          step_d  = 1'b1;
          w_d     = sw_s_q;
          count_d = count_q + COUNT_W'(1);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HELD: begin
        cnt_d = '0;
        if (key_s_q) state_d = RELEASE_WAIT;
      end
      RELEASE_WAIT: begin
        if (!key_s_q) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    // Registered from the next state so the level never glitches on a decode.
    pressed_d = (state_d == HELD) || (state_d == RELEASE_WAIT);
  end

  assign step       = step_q;
  assign w_out      = w_q;
  assign pressed    = pressed_q;
  assign step_count = count_q;

endmodule
